// File: rtl/dsc_pkg.sv
// rtl/dsc_pkg.sv - shared PPS constants, byte offsets, state encoding and config record
package dsc_pkg;

    localparam int PPS_BYTES = 128;
    localparam logic [6:0] PPS_LAST_BYTE = 7'(PPS_BYTES - 1);

    // Byte offsets of the first (most significant) byte of each PPS field
    localparam logic [6:0] PPS_OFS_BPC     = 7'd3;
    localparam logic [6:0] PPS_OFS_BPP     = 7'd4;
    localparam logic [6:0] PPS_OFS_PIC_H   = 7'd6;
    localparam logic [6:0] PPS_OFS_PIC_W   = 7'd8;
    localparam logic [6:0] PPS_OFS_SLICE_H = 7'd10;
    localparam logic [6:0] PPS_OFS_SLICE_W = 7'd12;
    localparam logic [6:0] PPS_OFS_CHUNK   = 7'd14;

    typedef enum logic [1:0] {
        PPS_IDLE    = 2'd0,
        PPS_HDR     = 2'd1,
        PPS_PAYLOAD = 2'd2
    } pps_state_t;

    typedef struct packed {
        logic [15:0] pic_width;
        logic [15:0] pic_height;
        logic [15:0] slice_width;
        logic [15:0] slice_height;
        logic [9:0]  bpp;
        logic [3:0]  bpc;
        logic [15:0] chunk_size;
    } dsc_cfg_t;

endpackage

// File: rtl/dsc_pps_skid.sv
// rtl/dsc_pps_skid.sv - one-entry registered output stage for the payload stream
// Ports: in_valid/in_ready/in_data/in_last load side; m_valid/m_ready/m_data/m_last
//        downstream side. in_valid must only be asserted while in_ready is high.
module dsc_pps_skid (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last
);

    // The entry can be refilled in the same cycle it is being drained.
    assign in_ready = !m_valid || m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 8'd0;
            m_last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_last  <= in_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dsc_pps_parser.sv
// rtl/dsc_pps_parser.sv - DSC PPS header parser with chunked payload pass-through
// Build option: DSC_PPS_CHECK_EN adds version, bpc and slice-size checks at commit.
// Ports: clk, rst_n; s_valid/s_ready/s_data/s_sof byte stream in (s_sof = PPS byte 0);
//        m_valid/m_ready/m_data/m_last payload out (m_last = last byte of a chunk);
//        cfg_* committed PPS fields; cfg_valid; err (sticky until next s_sof).
module dsc_pps_parser
    import dsc_pkg::*;
#(
    parameter int CHUNK_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [7:0]         s_data,
    input  logic               s_sof,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [7:0]         m_data,
    output logic               m_last,
    output logic [15:0]        cfg_pic_width,
    output logic [15:0]        cfg_pic_height,
    output logic [15:0]        cfg_slice_width,
    output logic [15:0]        cfg_slice_height,
    output logic [9:0]         cfg_bpp,
    output logic [3:0]         cfg_bpc,
    output logic [CHUNK_W-1:0] cfg_chunk_size,
    output logic               cfg_valid,
    output logic               err
);

    localparam logic [1:0] ST_IDLE    = PPS_IDLE;
    localparam logic [1:0] ST_HDR     = PPS_HDR;
    localparam logic [1:0] ST_PAYLOAD = PPS_PAYLOAD;

    logic [1:0]         state;
    logic [6:0]         hdr_cnt;
    logic [CHUNK_W-1:0] chunk_cnt;
    dsc_cfg_t           shadow;
    dsc_cfg_t           cfg;
    logic               s_acc;
    logic               stage_ready;
    logic               stage_load;
    logic               chunk_end;
    logic               hdr_bad;

`ifdef DSC_PPS_CHECK_EN
    localparam logic [7:0] PPS_VERSION = 8'h12;
    logic [7:0] sh_byte0;
`endif

    // The output stage gates input in every state so a byte still held there
    // after a header restart drains before anything new is accepted.
    assign s_ready    = stage_ready;
    assign s_acc      = s_valid && stage_ready;
    assign stage_load = s_acc && !s_sof && (state == ST_PAYLOAD);
    assign chunk_end  = (chunk_cnt == cfg_chunk_size - CHUNK_W'(1));

    assign cfg_pic_width    = cfg.pic_width;
    assign cfg_pic_height   = cfg.pic_height;
    assign cfg_slice_width  = cfg.slice_width;
    assign cfg_slice_height = cfg.slice_height;
    assign cfg_bpp          = cfg.bpp;
    assign cfg_bpc          = cfg.bpc;
    assign cfg_chunk_size   = CHUNK_W'(cfg.chunk_size);

    always_comb begin
        hdr_bad = (CHUNK_W'(shadow.chunk_size) == '0);
`ifdef DSC_PPS_CHECK_EN
        if ((sh_byte0 != PPS_VERSION) ||
            !(shadow.bpc inside {4'd8, 4'd10, 4'd12}) ||
            (shadow.slice_width == 16'd0) || (shadow.slice_height == 16'd0))
            hdr_bad = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hdr_cnt   <= 7'd0;
            chunk_cnt <= '0;
            shadow    <= '0;
            cfg       <= '0;
            cfg_valid <= 1'b0;
            err       <= 1'b0;
`ifdef DSC_PPS_CHECK_EN
            sh_byte0  <= 8'd0;
`endif
        end else if (s_acc) begin
            if (s_sof) begin
                // sof wins in every state, including on header byte 127
                state     <= ST_HDR;
                hdr_cnt   <= 7'd1;
                chunk_cnt <= '0;
                shadow    <= '0;
                cfg_valid <= 1'b0;
                err       <= 1'b0;
`ifdef DSC_PPS_CHECK_EN
                sh_byte0  <= s_data;
`endif
            end else begin
                case (state)
                    ST_HDR: begin
                        hdr_cnt <= hdr_cnt + 7'd1;
                        case (hdr_cnt)
                            PPS_OFS_BPC:            shadow.bpc                <= s_data[7:4];
                            PPS_OFS_BPP:            shadow.bpp[9:8]           <= s_data[1:0];
                            PPS_OFS_BPP + 7'd1:     shadow.bpp[7:0]           <= s_data;
                            PPS_OFS_PIC_H:          shadow.pic_height[15:8]   <= s_data;
                            PPS_OFS_PIC_H + 7'd1:   shadow.pic_height[7:0]    <= s_data;
                            PPS_OFS_PIC_W:          shadow.pic_width[15:8]    <= s_data;
                            PPS_OFS_PIC_W + 7'd1:   shadow.pic_width[7:0]     <= s_data;
                            PPS_OFS_SLICE_H:        shadow.slice_height[15:8] <= s_data;
                            PPS_OFS_SLICE_H + 7'd1: shadow.slice_height[7:0]  <= s_data;
                            PPS_OFS_SLICE_W:        shadow.slice_width[15:8]  <= s_data;
                            PPS_OFS_SLICE_W + 7'd1: shadow.slice_width[7:0]   <= s_data;
                            PPS_OFS_CHUNK:          shadow.chunk_size[15:8]   <= s_data;
                            PPS_OFS_CHUNK + 7'd1:   shadow.chunk_size[7:0]    <= s_data;
                            default: ;
                        endcase
                        if (hdr_cnt == PPS_LAST_BYTE) begin
                            // All fields live below byte 16, so shadows are final here.
                            cfg       <= shadow;
                            chunk_cnt <= '0;
                            if (hdr_bad) begin
                                err   <= 1'b1;
                                state <= ST_IDLE;
                            end else begin
                                cfg_valid <= 1'b1;
                                state     <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        chunk_cnt <= chunk_end ? '0 : chunk_cnt + CHUNK_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    dsc_pps_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (stage_load),
        .in_ready (stage_ready),
        .in_data  (s_data),
        .in_last  (chunk_end),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

endmodule

// File: tb/tb_dsc_pps_parser.sv
// tb/tb_dsc_pps_parser.sv - directed self-checking bench for dsc_pps_parser
module tb_dsc_pps_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_sof;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] cfg_pic_width;
    logic [15:0] cfg_pic_height;
    logic [15:0] cfg_slice_width;
    logic [15:0] cfg_slice_height;
    logic [9:0]  cfg_bpp;
    logic [3:0]  cfg_bpc;
    logic [15:0] cfg_chunk_size;
    logic        cfg_valid;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [7:0] hdr [0:127];
    logic [8:0] out_q [$];

    always #5 clk = ~clk;

    dsc_pps_parser #(.CHUNK_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_sof            (s_sof),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .m_last           (m_last),
        .cfg_pic_width    (cfg_pic_width),
        .cfg_pic_height   (cfg_pic_height),
        .cfg_slice_width  (cfg_slice_width),
        .cfg_slice_height (cfg_slice_height),
        .cfg_bpp          (cfg_bpp),
        .cfg_bpc          (cfg_bpc),
        .cfg_chunk_size   (cfg_chunk_size),
        .cfg_valid        (cfg_valid),
        .err              (err)
    );

    // Records each output handshake that will complete on the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) out_q.push_back({m_last, m_data});
    end

    // Inputs change at posedge+1; acceptance is judged at the preceding negedge.
    task automatic send(input logic [7:0] d, input logic sof);
        int w;
        w = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        @(negedge clk);
        while (!s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout s_ready=%b required=1", s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic build_hdr(input logic [3:0] bpc, input logic [9:0] bpp,
                             input logic [15:0] ph, input logic [15:0] pw,
                             input logic [15:0] sh, input logic [15:0] sw,
                             input logic [15:0] ch);
        for (int i = 0; i < 128; i++) hdr[i] = 8'(i * 7 + 3);
        hdr[0]  = 8'h12;
        hdr[3]  = {bpc, 4'h5};
        hdr[4]  = {6'b101010, bpp[9:8]};
        hdr[5]  = bpp[7:0];
        hdr[6]  = ph[15:8]; hdr[7]  = ph[7:0];
        hdr[8]  = pw[15:8]; hdr[9]  = pw[7:0];
        hdr[10] = sh[15:8]; hdr[11] = sh[7:0];
        hdr[12] = sw[15:8]; hdr[13] = sw[7:0];
        hdr[14] = ch[15:8]; hdr[15] = ch[7:0];
    endtask

    task automatic send_hdr(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(hdr[i], i == 0);
    endtask

    task automatic send_payload(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) send(base + 8'(i), 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0; s_sof = 1'b0; m_ready = 1'b1;
        idle(2);
        checks++;
        if ({m_valid, m_data, m_last, cfg_valid, err} !== 12'd0) begin
            failures++;
            $display("FAIL reset_out got=%h required=0", {m_valid, m_data, m_last, cfg_valid, err});
        end
        checks++;
        if ({cfg_pic_width, cfg_pic_height, cfg_slice_width, cfg_slice_height,
             cfg_bpp, cfg_bpc, cfg_chunk_size} !== 94'd0) begin
            failures++;
            $display("FAIL reset_cfg got nonzero cfg fields");
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_s_ready got=%b required=1", s_ready);
        end
    endtask

    task automatic test_basic();
        int bad;
        logic [8:0] exp;
        build_hdr(4'd8, 10'h0C0, 16'd1080, 16'd1920, 16'd108, 16'd480, 16'd180);
        send_hdr(0, 126);
        checks++;
        if (cfg_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_cfg_valid_early got=%b required=0", cfg_valid);
        end
        send_hdr(127, 127);
        checks++;
        if (cfg_valid !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_cfg_valid got=%b err=%b required=1/0", cfg_valid, err);
        end
        checks++;
        if (cfg_pic_width !== 16'd1920 || cfg_pic_height !== 16'd1080) begin
            failures++;
            $display("FAIL basic_pic got=%0dx%0d required=1920x1080", cfg_pic_width, cfg_pic_height);
        end
        checks++;
        if (cfg_slice_width !== 16'd480 || cfg_slice_height !== 16'd108) begin
            failures++;
            $display("FAIL basic_slice got=%0dx%0d required=480x108", cfg_slice_width, cfg_slice_height);
        end
        checks++;
        if (cfg_bpc !== 4'd8 || cfg_bpp !== 10'h0C0 || cfg_chunk_size !== 16'd180) begin
            failures++;
            $display("FAIL basic_fmt got bpc=%0d bpp=%h chunk=%0d required 8/0c0/180",
                     cfg_bpc, cfg_bpp, cfg_chunk_size);
        end
        out_q.delete();
        m_ready = 1'b1;
        send_payload(360, 8'h10);
        idle(3);
        checks++;
        if (out_q.size() != 360) begin
            failures++;
            $display("FAIL basic_count got=%0d required=360", out_q.size());
        end
        bad = 0;
        for (int i = 0; i < 360; i++) begin
            exp = {(i == 179 || i == 359), 8'h10 + 8'(i)};
            if (i < out_q.size() && out_q[i] !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL basic_data_last got=%0d bad bytes required=0", bad);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        logic stalled;
        logic [8:0] held;
        out_q.delete();
        fork
            send_payload(50, 8'h40);
            begin
                stalled = 1'b0;
                held = 9'd0;
                for (int c = 0; c < 160; c++) begin
                    @(negedge clk);
                    if (stalled) begin
                        checks++;
                        if (m_valid !== 1'b1 || {m_last, m_data} !== held) begin
                            failures++;
                            $display("FAIL bp_hold got=%b/%h required=1/%h",
                                     m_valid, {m_last, m_data}, held);
                        end
                    end
                    stalled = m_valid && !m_ready;
                    held = {m_last, m_data};
                    @(posedge clk);
                    #1;
                    m_ready = ~m_ready;
                end
                m_ready = 1'b1;
            end
        join
        idle(3);
        checks++;
        if (out_q.size() != 50) begin
            failures++;
            $display("FAIL bp_count got=%0d required=50", out_q.size());
        end
        bad = 0;
        for (int i = 0; i < 50 && i < out_q.size(); i++)
            if (out_q[i] !== {1'b0, 8'h40 + 8'(i)}) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_order got=%0d bad bytes required=0", bad);
        end
    endtask

    task automatic test_sof_restart();
        out_q.delete();
        m_ready = 1'b0;
        send(8'hC3, 1'b0);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'hC3) begin
            failures++;
            $display("FAIL sof_held_stage got rdy=%b v=%b d=%h required 0/1/c3", s_ready, m_valid, m_data);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        build_hdr(4'd10, 10'h155, 16'd500, 16'd600, 16'd50, 16'd100, 16'd64);
        send_hdr(0, 0);
        checks++;
        if (cfg_valid !== 1'b0) begin
            failures++;
            $display("FAIL sof_cfg_drop got=%b required=0", cfg_valid);
        end
        send_hdr(1, 59);
        build_hdr(4'd12, 10'h100, 16'd720, 16'd1280, 16'd360, 16'd640, 16'd300);
        send_hdr(0, 126);
        checks++;
        if (cfg_valid !== 1'b0) begin
            failures++;
            $display("FAIL sof_cfg_valid_early got=%b required=0", cfg_valid);
        end
        send_hdr(127, 127);
        checks++;
        if (cfg_valid !== 1'b1 || cfg_bpc !== 4'd12 || cfg_bpp !== 10'h100 ||
            cfg_pic_width !== 16'd1280 || cfg_pic_height !== 16'd720 ||
            cfg_slice_width !== 16'd640 || cfg_slice_height !== 16'd360 ||
            cfg_chunk_size !== 16'd300) begin
            failures++;
            $display("FAIL sof_cfg got v=%b bpc=%0d bpp=%h pic=%0dx%0d slice=%0dx%0d chunk=%0d",
                     cfg_valid, cfg_bpc, cfg_bpp, cfg_pic_width, cfg_pic_height,
                     cfg_slice_width, cfg_slice_height, cfg_chunk_size);
        end
        checks++;
        if (out_q.size() != 1 || out_q[0] !== 9'h0C3) begin
            failures++;
            $display("FAIL sof_drain got=%0d entries required 1 entry 0c3", out_q.size());
        end
    endtask

    task automatic test_chunk_zero();
        int bad;
        build_hdr(4'd8, 10'h0C0, 16'd100, 16'd200, 16'd10, 16'd20, 16'd0);
        send_hdr(0, 127);
        checks++;
        if (err !== 1'b1 || cfg_valid !== 1'b0) begin
            failures++;
            $display("FAIL cz_err got err=%b v=%b required 1/0", err, cfg_valid);
        end
        out_q.delete();
        m_ready = 1'b1;
        send_payload(20, 8'h80);
        idle(3);
        checks++;
        if (out_q.size() != 0) begin
            failures++;
            $display("FAIL cz_drop got=%0d outputs required=0", out_q.size());
        end
        build_hdr(4'd8, 10'h0C0, 16'd100, 16'd200, 16'd10, 16'd20, 16'd4);
        send_hdr(0, 0);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL cz_err_clear got=%b required=0", err);
        end
        send_hdr(1, 127);
        send_payload(10, 8'hA0);
        idle(3);
        checks++;
        if (cfg_valid !== 1'b1 || out_q.size() != 10) begin
            failures++;
            $display("FAIL cz_recover got v=%b n=%0d required 1/10", cfg_valid, out_q.size());
        end
        bad = 0;
        for (int i = 0; i < 10 && i < out_q.size(); i++)
            if (out_q[i] !== {(i % 4 == 3), 8'hA0 + 8'(i)}) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL cz_data got=%0d bad bytes required=0", bad);
        end
    endtask

    task automatic test_bpc9();
        int exp_n;
        build_hdr(4'd9, 10'h0C0, 16'd100, 16'd200, 16'd10, 16'd20, 16'd100);
        send_hdr(0, 127);
        out_q.delete();
        send_payload(5, 8'h33);
        idle(3);
`ifdef DSC_PPS_CHECK_EN
        exp_n = 0;
        checks++;
        if (err !== 1'b1 || cfg_valid !== 1'b0) begin
            failures++;
            $display("FAIL bpc9_check got err=%b v=%b required 1/0", err, cfg_valid);
        end
`else
        exp_n = 5;
        checks++;
        if (err !== 1'b0 || cfg_valid !== 1'b1 || cfg_bpc !== 4'd9) begin
            failures++;
            $display("FAIL bpc9_nocheck got err=%b v=%b bpc=%0d required 0/1/9", err, cfg_valid, cfg_bpc);
        end
`endif
        checks++;
        if (out_q.size() != exp_n) begin
            failures++;
            $display("FAIL bpc9_payload got=%0d required=%0d", out_q.size(), exp_n);
        end
    endtask

    task automatic test_reset_mid();
        build_hdr(4'd8, 10'h0C0, 16'd1080, 16'd1920, 16'd108, 16'd480, 16'd180);
        send_hdr(0, 127);
        send_payload(37, 8'h01);
        checks++;
        if (m_valid !== 1'b1 || cfg_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre got v=%b cfg_valid=%b required 1/1", m_valid, cfg_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_data, m_last, cfg_valid, err} !== 12'd0 ||
            {cfg_pic_width, cfg_pic_height, cfg_slice_width, cfg_slice_height,
             cfg_bpp, cfg_bpc, cfg_chunk_size} !== 94'd0) begin
            failures++;
            $display("FAIL rst_async got v=%b d=%h l=%b cv=%b e=%b chunk=%0d required 0",
                     m_valid, m_data, m_last, cfg_valid, err, cfg_chunk_size);
        end
        idle(1);
        rst_n = 1'b1;
        out_q.delete();
        send_payload(10, 8'h55);
        idle(3);
        checks++;
        if (out_q.size() != 0 || cfg_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_drop got n=%0d cfg_valid=%b required 0/0", out_q.size(), cfg_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_sof_restart();
        test_chunk_zero();
        test_bpc9();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsc_pps_parser.md
DSC_PPS_PARSER -- requirements
Module: dsc_pps_parser

Interface
REQ-001 SHALL have parameter CHUNK_W, default 16, width of the chunk byte counter and the cfg_chunk_size output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have the upstream byte-stream ports s_valid (in, 1), s_ready (out, 1), s_data (in, 8) and s_sof (in, 1); s_sof marks PPS byte 0.
REQ-005 SHALL have the downstream payload ports m_valid (out, 1), m_ready (in, 1), m_data (out, 8) and m_last (out, 1); m_last marks the last byte of a chunk.
REQ-006 SHALL have the configuration outputs cfg_pic_width, cfg_pic_height, cfg_slice_width and cfg_slice_height (out, 16 each).
REQ-007 SHALL have the configuration outputs cfg_bpp (out, 10, in 1/16 bpp units), cfg_bpc (out, 4) and cfg_chunk_size (out, CHUNK_W).
REQ-008 SHALL have the status outputs cfg_valid (out, 1) and err (out, 1).

Function
REQ-009 SHALL implement FSM states IDLE, HDR and PAYLOAD; an input byte is accepted only when s_valid and s_ready are both high.
REQ-010 In IDLE: s_ready=1; bytes without s_sof are dropped; an accepted byte with s_sof moves the FSM to HDR and counts as byte 0 (hdr_cnt becomes 1).
REQ-011 In HDR: s_ready=1; no m_valid; hdr_cnt counts 0..127; fields go into shadow registers.
REQ-011a Shadow field mapping: byte3[7:4] to bpc; byte4[1:0]:byte5 to bpp; bytes 6-7 to pic_height; bytes 8-9 to pic_width; bytes 10-11 to slice_height; bytes 12-13 to slice_width; bytes 14-15 to chunk_size; all big-endian, low CHUNK_W bits kept.
REQ-012 On acceptance of byte 127, shadows SHALL commit to cfg_*, cfg_valid SHALL rise the next cycle, and the FSM SHALL go to PAYLOAD with chunk_cnt=0.
REQ-013 In PAYLOAD, a one-entry registered output stage SHALL be used: s_ready = !m_valid || m_ready; latency 1 cycle from byte acceptance to m_valid; m_data/m_last held stable while m_valid && !m_ready.
REQ-014 m_last SHALL be 1 when chunk_cnt == cfg_chunk_size-1; chunk_cnt then wraps to 0, otherwise increments per accepted payload byte.
REQ-015 An accepted s_sof in HDR or PAYLOAD SHALL restart the header: that byte is PPS byte 0, cfg_valid drops next cycle, and the FSM enters HDR.
REQ-015a Any byte still held in the output stage SHALL still be delivered; s_ready stays low until it drains.
REQ-016 cfg_chunk_size == 0 at commit SHALL set err, keep the FSM in IDLE, and drop payload until the next s_sof.
REQ-017 Simultaneous s_sof and byte-127 acceptance cannot occur (byte 127 never carries sof); if s_sof is seen at byte 127, sof SHALL take priority and the header restarts.

Reset
REQ-018 While rst_n=0: FSM=IDLE; hdr_cnt, chunk_cnt and shadows =0; m_valid=0, m_data=0, m_last=0; all cfg_*=0; cfg_valid=0; err=0; s_ready=1 after release.
REQ-019 Reset asserted mid-header or mid-payload SHALL discard all partial state with no output glitch beyond the async clear.

Configuration
REQ-020 With DSC_PPS_CHECK_EN defined: at commit, err SHALL be set and the FSM SHALL go to IDLE if byte0 != 8'h12, cfg_bpc is not in {8,10,12}, slice_width==0, or slice_height==0.
REQ-020a err is sticky until the next accepted s_sof or reset.
REQ-021 Without DSC_PPS_CHECK_EN: only the REQ-016 check exists, and no version or range logic is synthesized.

Structure
REQ-022 Package dsc_pkg SHALL hold the PPS_BYTES=128 constant, the pps byte-offset localparams and the pps_state_t enum.
REQ-022a The cfg_* outputs map 1:1 onto dsc_cfg_t field semantics.
REQ-023 Sub-module dsc_pps_skid SHALL implement the one-entry output register of REQ-013.

Verification
REQ-024 Header with slice 480x108, bpc 8, bpp 0x0C0, chunk 180, then 360 bytes with m_ready=1 -> cfg_valid at cycle 129; m_last on payload bytes 180 and 360.
REQ-025 m_ready toggled 1/0 every cycle over 50 payload bytes -> byte order intact, no loss, m_data stable while stalled.
REQ-026 s_sof reasserted at header byte 60 -> header restarts; committed cfg uses only the second PPS; cfg_valid stays 0 until its byte 127.
REQ-027 chunk_size=0 header -> err=1, zero m_valid; next valid PPS with s_sof -> err=0 and payload flows.
REQ-028 With DSC_PPS_CHECK_EN, a header with bpc=9 -> err=1 and FSM in IDLE; without the macro, the same header -> cfg_valid=1 and cfg_bpc=9.
REQ-029 rst_n pulsed low at payload byte 37 -> all outputs 0 at once; bytes sent after reset without s_sof are dropped.
